// File: rtl/store_narrow_if.sv
// Store request and byte-wide memory write port bundle for the narrowing store unit.
// The slave modport is the store unit; the master modport is the pipeline/memory side.
interface store_narrow_if #(
    parameter int ADDR_W = 32
);
    logic              st_valid;
    logic              st_ready;
    logic [1:0]        st_size;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic              st_done;
    logic              st_misalign;

    modport slave (
        input  st_valid, st_size, st_addr, st_data, mem_ack,
        output st_ready, mem_wr, mem_addr, mem_wdata, st_done, st_misalign
    );

    modport master (
        output st_valid, st_size, st_addr, st_data, mem_ack,
        input  st_ready, mem_wr, mem_addr, mem_wdata, st_done, st_misalign
    );
endinterface

// File: rtl/store_narrow_unit.sv
// Narrowing store path: truncates a register to SB/SH/SW size and writes it to a
// byte-wide memory port one little-endian lane per acknowledged beat.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | st_ready high; accepts requests, rejects illegal ones in place
// WRITE | presenting beat k of the latched store until mem_ack
module store_narrow_unit #(
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    store_narrow_if.slave bus
);
    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [1:0]        last_q, last_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       data_q, data_d;

    logic              st_ready_q, st_ready_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              st_done_q, st_done_d;
    logic              st_misalign_q, st_misalign_d;

    logic              accept;
    logic              illegal;
    logic [1:0]        k_next;
    logic [1:0]        last_of_size;

    function automatic logic [7:0] lane(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    always_comb begin
        illegal = 1'b0;
        case (bus.st_size)
            2'b00:   illegal = 1'b0;
            2'b01:   illegal = bus.st_addr[0];
            2'b10:   illegal = (bus.st_addr[1:0] != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    // Beat counter compares against the index of the final beat, not the beat count.
    always_comb begin
        case (bus.st_size)
            2'b01:   last_of_size = 2'd1;
            2'b10:   last_of_size = 2'd3;
            default: last_of_size = 2'd0;
        endcase
    end

    assign accept = bus.st_valid && st_ready_q;
    assign k_next = k_q + 2'd1;

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        last_d        = last_q;
        base_d        = base_q;
        data_d        = data_q;
        st_ready_d    = st_ready_q;
        mem_wr_d      = mem_wr_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        st_done_d     = 1'b0;
        st_misalign_d = 1'b0;

        case (state_q)
            IDLE: begin
                st_ready_d = 1'b1;
                mem_wr_d   = 1'b0;
                if (accept) begin
                    if (illegal) begin
                        st_misalign_d = 1'b1;
                    end else begin
                        state_d     = WRITE;
                        k_d         = 2'd0;
                        last_d      = last_of_size;
                        base_d      = bus.st_addr;
                        data_d      = bus.st_data;
                        st_ready_d  = 1'b0;
                        mem_wr_d    = 1'b1;
                        mem_addr_d  = bus.st_addr;
                        mem_wdata_d = bus.st_data[7:0];
                    end
                end
            end

            WRITE: begin
                if (bus.mem_ack && mem_wr_q) begin
                    if (k_q == last_q) begin
                        state_d    = IDLE;
                        st_ready_d = 1'b1;
                        mem_wr_d   = 1'b0;
                        st_done_d  = 1'b1;
                    end else begin
                        k_d         = k_next;
                        mem_addr_d  = base_q + {{(ADDR_W-2){1'b0}}, k_next};
                        mem_wdata_d = lane(data_q, k_next);
                    end
                end
            end

            default: begin
                state_d    = IDLE;
                st_ready_d = 1'b1;
                mem_wr_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            k_q           <= 2'd0;
            last_q        <= 2'd0;
            base_q        <= '0;
            data_q        <= '0;
            st_ready_q    <= 1'b1;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            st_done_q     <= 1'b0;
            st_misalign_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            last_q        <= last_d;
            base_q        <= base_d;
            data_q        <= data_d;
            st_ready_q    <= st_ready_d;
            mem_wr_q      <= mem_wr_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            st_done_q     <= st_done_d;
            st_misalign_q <= st_misalign_d;
        end
    end

    assign bus.st_ready    = st_ready_q;
    assign bus.mem_wr      = mem_wr_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.st_done     = st_done_q;
    assign bus.st_misalign = st_misalign_q;
endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed bench for store_narrow_unit: a vector table of stores with hand-computed
// byte streams, plus sequences for illegal bursts, mid-store reset and back-to-back accept.
module tb_store_narrow_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    store_narrow_if #(.ADDR_W(32)) bus ();

    store_narrow_unit #(.ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        int          ack_dly;
        bit          exp_mis;
        int          exp_beats;
        logic [31:0] exp_bytes;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.st_valid = 1'b0;
        bus.st_size  = 2'b00;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.mem_ack  = 1'b0;
    endtask

    // Presents one request, then walks every beat with ack_dly wait cycles before each ack.
    task automatic run_vec(input vec_t v, input string tag);
        logic [7:0]  eb;
        logic [31:0] ea;
        chk({tag, "_ready_before"}, 64'(bus.st_ready), 64'd1);
        bus.st_valid = 1'b1;
        bus.st_size  = v.size;
        bus.st_addr  = v.addr;
        bus.st_data  = v.data;
        tick();
        bus.st_valid = 1'b0;
        if (v.exp_mis) begin
            chk({tag, "_misalign"}, 64'(bus.st_misalign), 64'd1);
            chk({tag, "_mis_no_wr"}, 64'(bus.mem_wr), 64'd0);
            chk({tag, "_mis_ready"}, 64'(bus.st_ready), 64'd1);
            chk({tag, "_mis_no_done"}, 64'(bus.st_done), 64'd0);
            tick();
            chk({tag, "_mis_pulse_end"}, 64'(bus.st_misalign), 64'd0);
            chk({tag, "_mis_no_wr2"}, 64'(bus.mem_wr), 64'd0);
        end else begin
            for (int b = 0; b < v.exp_beats; b++) begin
                eb = v.exp_bytes[8*b +: 8];
                ea = v.addr + 32'(b);
                for (int w = 0; w <= v.ack_dly; w++) begin
                    chk({tag, "_wr"}, 64'(bus.mem_wr), 64'd1);
                    chk({tag, "_addr"}, 64'(bus.mem_addr), 64'(ea));
                    chk({tag, "_wdata"}, 64'(bus.mem_wdata), 64'(eb));
                    chk({tag, "_busy"}, 64'(bus.st_ready), 64'd0);
                    chk({tag, "_no_early_done"}, 64'(bus.st_done), 64'd0);
                    chk({tag, "_no_mis"}, 64'(bus.st_misalign), 64'd0);
                    bus.mem_ack = (w == v.ack_dly);
                    tick();
                    bus.mem_ack = 1'b0;
                end
            end
            chk({tag, "_done"}, 64'(bus.st_done), 64'd1);
            chk({tag, "_done_wr_low"}, 64'(bus.mem_wr), 64'd0);
            chk({tag, "_done_ready"}, 64'(bus.st_ready), 64'd1);
            chk({tag, "_done_no_mis"}, 64'(bus.st_misalign), 64'd0);
            tick();
            chk({tag, "_done_pulse_end"}, 64'(bus.st_done), 64'd0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();

        //            size   addr           data           dly mis beats bytes (lane0 in [7:0])
        vecs[0] = '{2'b10, 32'h0000_0100, 32'hA1B2_C3D4, 0, 1'b0, 4, 32'hA1B2_C3D4};
        vecs[1] = '{2'b01, 32'h0000_0202, 32'hFFFF_1234, 2, 1'b0, 2, 32'h0000_1234};
        vecs[2] = '{2'b00, 32'h0000_0007, 32'h0000_00EE, 0, 1'b0, 1, 32'h0000_00EE};
        vecs[3] = '{2'b00, 32'h0000_0013, 32'h1234_5678, 1, 1'b0, 1, 32'h0000_0078};
        vecs[4] = '{2'b01, 32'h0000_0031, 32'h0000_BEEF, 0, 1'b1, 0, 32'h0000_0000};
        vecs[5] = '{2'b10, 32'h0000_0102, 32'hDEAD_BEEF, 0, 1'b1, 0, 32'h0000_0000};
        vecs[6] = '{2'b11, 32'h0000_0040, 32'h1111_1111, 0, 1'b1, 0, 32'h0000_0000};
        vecs[7] = '{2'b10, 32'hFFFF_FFFC, 32'h0BAD_F00D, 1, 1'b0, 4, 32'h0BAD_F00D};

        rst_n = 1'b0;
        #12;
        chk("rst_ready", 64'(bus.st_ready), 64'd1);
        chk("rst_wr", 64'(bus.mem_wr), 64'd0);
        chk("rst_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("rst_done", 64'(bus.st_done), 64'd0);
        chk("rst_mis", 64'(bus.st_misalign), 64'd0);
        #6 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Three illegal requests on consecutive cycles with st_valid held high.
        bus.st_valid = 1'b1;
        bus.st_size = 2'b10; bus.st_addr = 32'h102; bus.st_data = 32'h1;
        tick();
        chk("ill_sw_mis", 64'(bus.st_misalign), 64'd1);
        chk("ill_sw_ready", 64'(bus.st_ready), 64'd1);
        chk("ill_sw_wr", 64'(bus.mem_wr), 64'd0);
        bus.st_size = 2'b01; bus.st_addr = 32'h31;
        tick();
        chk("ill_sh_mis", 64'(bus.st_misalign), 64'd1);
        chk("ill_sh_ready", 64'(bus.st_ready), 64'd1);
        chk("ill_sh_wr", 64'(bus.mem_wr), 64'd0);
        bus.st_size = 2'b11; bus.st_addr = 32'h0;
        tick();
        chk("ill_11_mis", 64'(bus.st_misalign), 64'd1);
        chk("ill_11_ready", 64'(bus.st_ready), 64'd1);
        chk("ill_11_wr", 64'(bus.mem_wr), 64'd0);
        bus.st_valid = 1'b0;
        tick();
        chk("ill_end_mis", 64'(bus.st_misalign), 64'd0);
        chk("ill_end_wr", 64'(bus.mem_wr), 64'd0);

        // Reset during beat 2 of a word store aborts without st_done.
        bus.st_valid = 1'b1; bus.st_size = 2'b10;
        bus.st_addr = 32'h200; bus.st_data = 32'h4433_2211;
        tick();
        bus.st_valid = 1'b0;
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("rstmid_beat2_addr", 64'(bus.mem_addr), 64'h201);
        chk("rstmid_beat2_data", 64'(bus.mem_wdata), 64'h22);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_wr_drop", 64'(bus.mem_wr), 64'd0);
        chk("rstmid_ready", 64'(bus.st_ready), 64'd1);
        chk("rstmid_no_done", 64'(bus.st_done), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("rstmid_quiet_done", 64'(bus.st_done), 64'd0);
            chk("rstmid_quiet_wr", 64'(bus.mem_wr), 64'd0);
            tick();
        end
        run_vec(vecs[2], "post_rst_sb");

        // SB accepted in the same cycle the prior SH reports st_done.
        bus.st_valid = 1'b1; bus.st_size = 2'b01;
        bus.st_addr = 32'h300; bus.st_data = 32'h0000_ABCD;
        tick();
        bus.st_valid = 1'b0;
        bus.mem_ack = 1'b1;
        chk("b2b_sh0", 64'(bus.mem_wdata), 64'hCD);
        tick();
        chk("b2b_sh1_addr", 64'(bus.mem_addr), 64'h301);
        chk("b2b_sh1", 64'(bus.mem_wdata), 64'hAB);
        tick();
        bus.mem_ack = 1'b0;
        chk("b2b_sh_done", 64'(bus.st_done), 64'd1);
        chk("b2b_sh_ready", 64'(bus.st_ready), 64'd1);
        bus.st_valid = 1'b1; bus.st_size = 2'b00;
        bus.st_addr = 32'h55; bus.st_data = 32'hFFFF_FF5A;
        tick();
        bus.st_valid = 1'b0;
        chk("b2b_sb_wr", 64'(bus.mem_wr), 64'd1);
        chk("b2b_sb_addr", 64'(bus.mem_addr), 64'h55);
        chk("b2b_sb_data", 64'(bus.mem_wdata), 64'h5A);
        chk("b2b_sb_no_done", 64'(bus.st_done), 64'd0);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("b2b_sb_done", 64'(bus.st_done), 64'd1);
        chk("b2b_sb_wr_low", 64'(bus.mem_wr), 64'd0);
        tick();

        // Stray ack while idle must not start anything.
        bus.mem_ack = 1'b1;
        tick();
        tick();
        bus.mem_ack = 1'b0;
        chk("idle_ack_wr", 64'(bus.mem_wr), 64'd0);
        chk("idle_ack_done", 64'(bus.st_done), 64'd0);
        chk("idle_ack_ready", 64'(bus.st_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
